// File: rtl/gobang_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gobang_pkg
// Description : Shared types and constants for the GoBang board store.
//               point_t  - 2-bit state of one board point
//               bstate_t - controller state of the board store
// Revision    : 1.0 - initial release
// ============================================================================
package gobang_pkg;

    localparam int DEFAULT_BOARD_SIZE = 15;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        WHITE = 2'b01,
        BLACK = 2'b10
    } point_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bstate_t;

endpackage
`default_nettype wire

// File: rtl/board_state_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : board_state_memory_if
// Description : Placement handshake between the game controller (master)
//               and the board store (slave).
//   place_valid  M->S  placement request
//   place_ready  S->M  store can accept a placement this cycle
//   place_x/y    M->S  coordinates of the placement
//   place_colour M->S  colour to place (01 white, 10 black)
//   place_done   S->M  one-cycle result pulse
//   place_ok     S->M  result qualifier: 1 accepted, 0 rejected
// Revision    : 1.0 - initial release
// ============================================================================
interface board_state_memory_if #(
    parameter int COORD_W = 4
) ();
    logic               place_valid;
    logic               place_ready;
    logic [COORD_W-1:0] place_x;
    logic [COORD_W-1:0] place_y;
    logic [1:0]         place_colour;
    logic               place_done;
    logic               place_ok;

    modport master (
        output place_valid, place_x, place_y, place_colour,
        input  place_ready, place_done, place_ok
    );

    modport slave (
        input  place_valid, place_x, place_y, place_colour,
        output place_ready, place_done, place_ok
    );
endinterface
`default_nettype wire

// File: rtl/board_point_cell.sv
`default_nettype none
// ============================================================================
// Module      : board_point_cell
// Description : State register for a single board point.
//   clock        in   system clock
//   reset        in   synchronous active-high reset (clears to 00)
//   write_enable in   load write_data at the next rising edge
//   write_data   in   new 2-bit point state
//   state        out  current 2-bit point state
// Revision    : 1.0 - initial release
// ============================================================================
module board_point_cell (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       write_enable,
    input  wire logic [1:0] write_data,
    output logic      [1:0] state
);
    logic [1:0] state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= 2'b00;
        end else if (write_enable) begin
            state_q <= write_data;
        end
    end

    assign state = state_q;
endmodule
`default_nettype wire

// File: rtl/board_state_memory.sv
`default_nettype none
// ============================================================================
// Module      : board_state_memory
// Description : BOARD_SIZE x BOARD_SIZE GoBang board store. Accepts and
//               legality-checks stone placements, offers a registered read
//               port and performs a one-cell-per-cycle board clear sweep.
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   clear_req   in   start a full-board clear sweep
//   place_if    slv  placement handshake (board_state_memory_if.slave)
//   rd_x/rd_y   in   read coordinates
//   rd_data     out  registered point state, 1-cycle latency
//   move_count  out  stones currently on the board
//   last_x/y    out  coordinates of the last accepted stone
//   board_full  out  move_count == BOARD_SIZE**2
//   busy        out  clear sweep in progress
// Revision    : 1.0 - initial release
// ============================================================================
module board_state_memory
    import gobang_pkg::*;
#(
    parameter int BOARD_SIZE = DEFAULT_BOARD_SIZE,
    parameter int COORD_W    = 4,
    parameter int COUNT_W    = 8
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic               clear_req,
    board_state_memory_if.slave     place_if,
    input  wire logic [COORD_W-1:0] rd_x,
    input  wire logic [COORD_W-1:0] rd_y,
    output logic      [1:0]         rd_data,
    output logic      [COUNT_W-1:0] move_count,
    output logic      [COORD_W-1:0] last_x,
    output logic      [COORD_W-1:0] last_y,
    output logic                    board_full,
    output logic                    busy
);
    localparam int                 NUM_CELLS  = BOARD_SIZE * BOARD_SIZE;
    localparam logic [COUNT_W-1:0] LAST_IDX   = COUNT_W'(NUM_CELLS - 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(NUM_CELLS);

    // Compare one bit wider so BOARD_SIZE == 2**COORD_W does not truncate.
    function automatic logic coord_in_range(input logic [COORD_W-1:0] c);
        return ({1'b0, c} < (COORD_W + 1)'(BOARD_SIZE));
    endfunction

    function automatic logic [COUNT_W-1:0] cell_index(input logic [COORD_W-1:0] x,
                                                      input logic [COORD_W-1:0] y);
        return COUNT_W'(y) * COUNT_W'(BOARD_SIZE) + COUNT_W'(x);
    endfunction

    bstate_t            state_q, state_d;
    logic [COUNT_W-1:0] sweep_q, sweep_d;
    logic [COUNT_W-1:0] move_count_q, move_count_d;
    logic [COORD_W-1:0] last_x_q, last_x_d;
    logic [COORD_W-1:0] last_y_q, last_y_d;
    logic               place_done_q, place_done_d;
    logic               place_ok_q, place_ok_d;
    logic [1:0]         rd_data_q, rd_data_d;

    logic [1:0]           cell_state [NUM_CELLS];
    logic [NUM_CELLS-1:0] cell_we;
    logic [1:0]           cell_wdata;

    logic               place_ready;
    logic               place_fire;
    logic               place_legal;
    logic               place_in_range;
    logic               colour_ok;
    logic [COUNT_W-1:0] place_idx;
    logic [COUNT_W-1:0] rd_idx;
    logic [1:0]         target_state;

    // ------------------------------------------------------------------
    // Cell array
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cells
        board_point_cell u_cell (
            .clock        (clock),
            .reset        (reset),
            .write_enable (cell_we[gi]),
            .write_data   (cell_wdata),
            .state        (cell_state[gi])
        );
    end

    // ------------------------------------------------------------------
    // Legality check and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        place_ready    = (state_q == IDLE) && !clear_req;
        place_fire     = place_if.place_valid && place_ready;
        place_idx      = cell_index(place_if.place_x, place_if.place_y);
        place_in_range = coord_in_range(place_if.place_x) &&
                         coord_in_range(place_if.place_y);
        colour_ok      = (place_if.place_colour == WHITE) ||
                         (place_if.place_colour == BLACK);

        // An out-of-range coordinate can alias a real cell index, so the
        // lookup result is only meaningful together with place_in_range.
        target_state = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (COUNT_W'(i) == place_idx) begin
                target_state = cell_state[i];
            end
        end

        place_legal = place_in_range && colour_ok && (target_state == EMPTY) &&
                      (move_count_q != FULL_COUNT);

        state_d      = state_q;
        sweep_d      = sweep_q;
        move_count_d = move_count_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        place_done_d = 1'b0;
        place_ok_d   = 1'b0;
        cell_we      = '0;
        cell_wdata   = EMPTY;

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d      = CLEAR;
                    sweep_d      = '0;
                    move_count_d = '0;
                    last_x_d     = '0;
                    last_y_d     = '0;
                end else if (place_fire) begin
                    place_done_d = 1'b1;
                    if (place_legal) begin
                        place_ok_d   = 1'b1;
                        cell_wdata   = place_if.place_colour;
                        move_count_d = move_count_q + 1'b1;
                        last_x_d     = place_if.place_x;
                        last_y_d     = place_if.place_y;
                        for (int i = 0; i < NUM_CELLS; i++) begin
                            cell_we[i] = (COUNT_W'(i) == place_idx);
                        end
                    end
                end
            end
            CLEAR: begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    cell_we[i] = (COUNT_W'(i) == sweep_q);
                end
                if (sweep_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read mux sees pre-edge cell contents, so a same-cycle write
        // shows up one cycle later.
        rd_idx    = cell_index(rd_x, rd_y);
        rd_data_d = EMPTY;
        if (coord_in_range(rd_x) && coord_in_range(rd_y)) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                if (COUNT_W'(i) == rd_idx) begin
                    rd_data_d = cell_state[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Controller state and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            sweep_q      <= '0;
            move_count_q <= '0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            place_done_q <= 1'b0;
            place_ok_q   <= 1'b0;
            rd_data_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            move_count_q <= move_count_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            place_done_q <= place_done_d;
            place_ok_q   <= place_ok_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign place_if.place_ready = place_ready;
    assign place_if.place_done  = place_done_q;
    assign place_if.place_ok    = place_ok_q;
    assign rd_data              = rd_data_q;
    assign move_count           = move_count_q;
    assign last_x               = last_x_q;
    assign last_y               = last_y_q;
    assign board_full           = (move_count_q == FULL_COUNT);
    assign busy                 = (state_q == CLEAR);
endmodule
`default_nettype wire

// File: tb/tb_board_state_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_state_memory
// Description : Directed self-checking bench for board_state_memory
//               (BOARD_SIZE = 15). Inputs change and outputs are sampled on
//               the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_state_memory;

    localparam int BOARD_SIZE = 15;
    localparam int COORD_W    = 4;
    localparam int COUNT_W    = 8;
    localparam int NUM_CELLS  = BOARD_SIZE * BOARD_SIZE;

    logic               clock = 1'b0;
    logic               reset;
    logic               clear_req;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [1:0]         rd_data;
    logic [COUNT_W-1:0] move_count;
    logic [COORD_W-1:0] last_x;
    logic [COORD_W-1:0] last_y;
    logic               board_full;
    logic               busy;

    board_state_memory_if #(.COORD_W(COORD_W)) pif ();

    board_state_memory #(
        .BOARD_SIZE (BOARD_SIZE),
        .COORD_W    (COORD_W),
        .COUNT_W    (COUNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .place_if   (pif.slave),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_data    (rd_data),
        .move_count (move_count),
        .last_x     (last_x),
        .last_y     (last_y),
        .board_full (board_full),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_place(input int x, input int y, input int c,
                            output logic done, output logic ok);
        pif.place_valid  = 1'b1;
        pif.place_x      = 4'(x);
        pif.place_y      = 4'(y);
        pif.place_colour = 2'(c);
        @(negedge clock);
        done = pif.place_done;
        ok   = pif.place_ok;
        pif.place_valid = 1'b0;
    endtask

    task automatic read_cell(input int x, input int y, output logic [1:0] val);
        rd_x = 4'(x);
        rd_y = 4'(y);
        @(negedge clock);
        val = rd_data;
    endtask

    // Counts non-empty cells across the whole board.
    task automatic count_occupied(output int occ);
        logic [1:0] v;
        occ = 0;
        for (int y = 0; y < BOARD_SIZE; y++) begin
            for (int x = 0; x < BOARD_SIZE; x++) begin
                read_cell(x, y, v);
                if (v != 2'b00) occ++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       done, ok;
        logic [1:0] v;
        int         occ, busy_cycles, oks;

        reset            = 1'b1;
        clear_req        = 1'b0;
        rd_x             = '0;
        rd_y             = '0;
        pif.place_valid  = 1'b0;
        pif.place_x      = '0;
        pif.place_y      = '0;
        pif.place_colour = 2'b00;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check_value("rst_move_count", 32'(move_count), 0);
        check_value("rst_busy", 32'(busy), 0);
        check_value("rst_ready", 32'(pif.place_ready), 1);
        check_value("rst_done", 32'(pif.place_done), 0);
        check_value("rst_full", 32'(board_full), 0);
        check_value("rst_rd_data", 32'(rd_data), 0);
        count_occupied(occ);
        check_value("rst_all_empty", 32'(occ), 0);

        // Legal placement
        do_place(7, 7, 2, done, ok);
        check_value("p1_done", 32'(done), 1);
        check_value("p1_ok", 32'(ok), 1);
        @(negedge clock);
        check_value("p1_done_pulse", 32'(pif.place_done), 0);
        read_cell(7, 7, v);
        check_value("p1_read", 32'(v), 2);
        check_value("p1_count", 32'(move_count), 1);
        check_value("p1_last_x", 32'(last_x), 7);
        check_value("p1_last_y", 32'(last_y), 7);

        // Rejects: occupied, bad colour, out of range
        do_place(7, 7, 1, done, ok);
        check_value("rej_occ_done", 32'(done), 1);
        check_value("rej_occ_ok", 32'(ok), 0);
        do_place(0, 0, 3, done, ok);
        check_value("rej_col_done", 32'(done), 1);
        check_value("rej_col_ok", 32'(ok), 0);
        do_place(15, 3, 2, done, ok);
        check_value("rej_oor_done", 32'(done), 1);
        check_value("rej_oor_ok", 32'(ok), 0);
        do_place(3, 15, 1, done, ok);
        check_value("rej_oory_ok", 32'(ok), 0);
        check_value("rej_count", 32'(move_count), 1);
        check_value("rej_last_x", 32'(last_x), 7);
        read_cell(0, 0, v);
        check_value("rej_col_cell", 32'(v), 0);
        read_cell(0, 4, v);   // index alias of (15,3)
        check_value("rej_alias_cell", 32'(v), 0);
        read_cell(15, 3, v);
        check_value("rd_oor", 32'(v), 0);

        // Same-edge write and read of (3,4)
        rd_x = 4'd3;
        rd_y = 4'd4;
        do_place(3, 4, 1, done, ok);
        check_value("rw_ok", 32'(ok), 1);
        check_value("rw_old", 32'(rd_data), 0);
        @(negedge clock);
        check_value("rw_new", 32'(rd_data), 1);

        // Back-to-back placements on the same cell
        pif.place_valid  = 1'b1;
        pif.place_x      = 4'd5;
        pif.place_y      = 4'd5;
        pif.place_colour = 2'b10;
        @(negedge clock);
        check_value("b2b_first_ok", 32'(pif.place_ok), 1);
        @(negedge clock);
        check_value("b2b_second_done", 32'(pif.place_done), 1);
        check_value("b2b_second_ok", 32'(pif.place_ok), 0);
        pif.place_valid = 1'b0;
        check_value("b2b_count", 32'(move_count), 3);

        // Clear with a simultaneous placement request
        clear_req        = 1'b1;
        pif.place_valid  = 1'b1;
        pif.place_x      = 4'd0;
        pif.place_y      = 4'd0;
        pif.place_colour = 2'b01;
        #1;
        check_value("clr_ready_low", 32'(pif.place_ready), 0);
        @(negedge clock);
        clear_req       = 1'b0;
        pif.place_valid = 1'b0;
        check_value("clr_no_done", 32'(pif.place_done), 0);
        check_value("clr_count_zero", 32'(move_count), 0);
        check_value("clr_ready_busy", 32'(pif.place_ready), 0);
        busy_cycles = 0;
        for (int t = 0; t < 400 && busy; t++) begin
            busy_cycles++;
            if (busy_cycles == 1) begin
                rd_x = 4'd7;
                rd_y = 4'd7;
            end
            if (busy_cycles == 2) check_value("clr_unswept", 32'(rd_data), 2);
            clear_req = (busy_cycles == 50);   // ignored mid-sweep
            @(negedge clock);
        end
        clear_req = 1'b0;
        check_value("clr_busy_cycles", 32'(busy_cycles), 225);
        check_value("clr_ready_after", 32'(pif.place_ready), 1);
        check_value("clr_last_y", 32'(last_y), 0);
        count_occupied(occ);
        check_value("clr_all_empty", 32'(occ), 0);

        // Reset mid-sweep
        do_place(14, 14, 2, done, ok);
        check_value("pre_rst_ok", 32'(ok), 1);
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        repeat (99) @(negedge clock);
        check_value("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_value("mid_rst_busy", 32'(busy), 0);
        check_value("mid_rst_rd", 32'(rd_data), 0);
        read_cell(14, 14, v);
        check_value("mid_rst_cell", 32'(v), 0);

        // Fill the board row-major with alternating colours
        oks = 0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            do_place(i % BOARD_SIZE, i / BOARD_SIZE, (i % 2 == 1) ? 1 : 2, done, ok);
            if (ok) oks++;
            if (i == NUM_CELLS - 2) check_value("fill_not_full", 32'(board_full), 0);
        end
        check_value("fill_oks", 32'(oks), 225);
        check_value("fill_count", 32'(move_count), 225);
        check_value("fill_full", 32'(board_full), 1);
        check_value("fill_last_x", 32'(last_x), 14);
        do_place(0, 0, 1, done, ok);
        check_value("full_rej_done", 32'(done), 1);
        check_value("full_rej_ok", 32'(ok), 0);
        check_value("full_count", 32'(move_count), 225);
        read_cell(1, 0, v);
        check_value("fill_cell_1_0", 32'(v), 1);
        read_cell(14, 14, v);
        check_value("fill_cell_14_14", 32'(v), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_state_memory.md
Name: board_state_memory

Overview:
Parametrised game-board store holding the 2-bit state of every point on a BOARD_SIZE x BOARD_SIZE GoBang board.
- Accepts placement requests over a valid/ready handshake and rejects illegal moves: occupied, out of range, or bad colour.
- Provides a registered random-access read port and a multi-cycle board-clear sequence.
- Sits between the game controller (move source), the win-checker and the VGA renderer (readers).

Parameters:
BOARD_SIZE, 15, points per row/column (legal 5..16)
COORD_W, 4, coordinate width; BOARD_SIZE <= 2**COORD_W
COUNT_W, 8, move-counter width; BOARD_SIZE**2 < 2**COUNT_W

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
clear_req  in  1  start full-board clear sweep
place_valid  in  1  placement request
place_ready  out  1  block can accept placement this cycle
place_x  in  COORD_W  column of placement
place_y  in  COORD_W  row of placement
place_colour  in  2  00 empty, 01 white, 10 black, 11 illegal
place_done  out  1  one-cycle pulse: placement result valid
place_ok  out  1  with place_done: 1 accepted, 0 rejected
rd_x  in  COORD_W  read column
rd_y  in  COORD_W  read row
rd_data  out  2  registered point state at (rd_x, rd_y)
move_count  out  COUNT_W  stones on board
last_x  out  COORD_W  column of last accepted stone
last_y  out  COORD_W  row of last accepted stone
board_full  out  1  move_count == BOARD_SIZE**2
busy  out  1  clear sweep in progress

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: all cells 00, rd_data 00, move_count 0, last_x/last_y 0, place_done 0, place_ok 0, board_full 0, busy 0, state IDLE.
  - Reset mid-clear or mid-placement aborts the operation. All cells are 00 on the next cycle.
- States:
  - IDLE: place_ready = !clear_req.
  - CLEAR: busy = 1, place_ready = 0.
- IDLE -> CLEAR when clear_req = 1.
  - clear_req has priority over a simultaneous place_valid; the placement is not accepted.
  - On entry: move_count <= 0, last_x/last_y <= 0, sweep index <= 0.
- CLEAR sweep:
  - Writes 00 to one cell per cycle in row-major order, index = y*BOARD_SIZE + x.
  - Takes BOARD_SIZE**2 cycles, then returns to IDLE.
  - clear_req during CLEAR is ignored, with no restart.
- Placement:
  - Accepted on the cycle place_valid & place_ready.
  - Legal iff x < BOARD_SIZE, y < BOARD_SIZE, colour is 01 or 10, and the cell is 00.
  - Legal move: the cell is written at that edge, move_count increments, and last_x/last_y update.
  - Illegal move: no state changes.
  - Result latency is one cycle: place_done = 1 for exactly one cycle, with place_ok.
  - Back-to-back placements on consecutive cycles are allowed. The second sees the first's write, so the same cell twice gives ok then reject.
- Full board: board_full is a combinational compare on move_count. move_count never exceeds BOARD_SIZE**2; every cell is then occupied, so all further placements reject.
- Read port:
  - rd_data is registered, with 1-cycle latency.
  - Out-of-range coordinates return 00.
  - A read of a cell written in the same cycle returns the old value; the new value appears the following cycle.
  - Reads during CLEAR return current contents: swept cells show 00, unswept cells keep their old values.

Decomposition:
- Shared package gobang_pkg:
  - point_t enum: EMPTY = 2'b00, WHITE = 2'b01, BLACK = 2'b10.
  - bstate_t enum: IDLE, CLEAR.
  - Default BOARD_SIZE constant.
- One natural sub-module, board_point_cell: a 2-bit register with write_enable and synchronous active-high reset, instanced BOARD_SIZE**2 times via generate.
- Parent owns the FSM, legality check, counters and read mux.

Test Plan:
- Reset, then read all cells -> rd_data 00 everywhere; move_count 0, busy 0, place_ready 1.
- Place BLACK at (7,7) -> next cycle place_done=1, place_ok=1. Read (7,7) -> 10; move_count 1; last_x=7, last_y=7.
- Place WHITE at (7,7), then colour 11 at (0,0), then BLACK at (15,3) with BOARD_SIZE=15 -> three rejects with place_ok=0; move_count stays 1.
- Assert clear_req and place_valid together -> placement not accepted, busy=1 for exactly 225 cycles. Afterwards all reads 00 and move_count 0. Reset asserted at sweep cycle 100 -> IDLE and all 00 next cycle.
- Fill all 225 cells alternating colours -> board_full=1 at move_count 225; the 226th placement rejects.
- Write (3,4) and read (3,4) on the same edge -> rd_data old value 00, then 01 the cycle after.
